serial_cmp_ctrl: RTL and testbench
==================================

// Module: serial_cmp_ctrl
// PURPOSE
//  Sequences one shared 2-bit magnitude-comparator slice (Two_Bit_Cmp) over two WIDTH-bit operands.
//  - Compares 2 bits per clock, MSB pair first.
//  - Returns a one-hot gt/eq/lt result with a start/done handshake.
//  - Sits between a requesting controller and the comparator datapath, so wide unsigned compares
//    can be built from the existing 2-bit slice.
// PARAMETERS
//  WIDTH  8  operand width in bits; must be even and >= 2; P = WIDTH/2 pairs
// PORTS
//  clk    in   1      rising-edge clock
//  rst_n  in   1      asynchronous, active-low reset
//  start  in   1      request; sampled only in IDLE
//  op_a   in   WIDTH  operand A, unsigned; latched on accepted start
//  op_b   in   WIDTH  operand B, unsigned; latched on accepted start
//  busy   out  1      high in RUN and DONE
//  done   out  1      one-cycle pulse; result valid
//  gt     out  1      A > B
//  eq     out  1      A == B
//  lt     out  1      A < B
// BEHAVIOUR
//  Interface: one clock (clk); reset rst_n is asynchronous and active-low.
//  Reset: state=IDLE; busy=0, done=0, gt=eq=lt=0; pair index=0; operand registers=0.
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE & start: latch op_a/op_b; idx=P-1; clear gt/eq/lt; go RUN.
//   - RUN: the slice sees A[2i+1:2i] / B[2i+1:2i] with i=idx.
//     Slice mapping: a,b = A msb,lsb; c,d = B msb,lsb; f1=gt, f2=eq, f3=lt.
//   - Sticky decision register: the first pair with f2=0 records f1/f3; later pairs are ignored.
//   - RUN exit: when idx==0, go DONE, load gt/eq/lt.
//     eq=1 only if every pair reported f2=1.
//     Otherwise idx decrements.
//   - DONE: done=1 for exactly one cycle; next edge -> IDLE.
//  Latency without early exit: start sampled at edge k -> done high after edge k+P, low after
//   edge k+P+1. WIDTH=8 -> 4 RUN cycles.
//  Results: exactly one of gt/eq/lt is high from the DONE cycle until the next accepted start.
//   All three are 0 from reset and during RUN.
//  start while busy (RUN or DONE): ignored; no queueing.
//   Operand changes after acceptance have no effect.
//  start in the same cycle done is high: ignored; requester re-asserts in IDLE.
//   Back-to-back throughput is one compare per P+2 cycles.
//  rst_n low mid-operation: immediate return to IDLE; all outputs 0; no done pulse.
//  WIDTH=2: a single RUN cycle.
// CONFIGURATION
//  Macro CMP_EARLY_EXIT_EN.
//  Defined: RUN exits to DONE on the first pair with f2=0, so latency = (P - i_first) RUN cycles.
//   An all-equal compare still takes P cycles.
//  Undefined: always P RUN cycles regardless of data; constant-time compare.
//  gt/eq/lt values are identical in both builds.
// STRUCTURE
//  Shared package cmp_pkg holds:
//   - typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} cmp_state_t
//   - result one-hot constants RES_GT=3'b100, RES_EQ=3'b010, RES_LT=3'b001
//  Sub-module: one instance of the existing Two_Bit_Cmp (combinational slice).
//   The pair mux, index counter and FSM stay in this module.
// TESTING (WIDTH=8 unless stated)
//  1. Reset: rst_n=0 -> busy=done=gt=eq=lt=0; release with start=0 -> all stay 0.
//  2. A=8'h5A, B=8'h5A, start 1 cycle -> busy 4 RUN + 1 DONE cycles; done pulse; eq=1, gt=lt=0.
//  3. A=8'hC0, B=8'h40 -> gt=1.
//     Early-exit build: done after 1 RUN cycle. Other build: after 4.
//  4. A=8'h03, B=8'h02 -> gt=1, decided at the LSB pair in both builds.
//     A=8'h00, B=8'hFF -> lt=1.
//  5. start held high through RUN/DONE with changing op_a/op_b -> first compare result unaffected;
//     a new compare starts only from IDLE.
//  6. rst_n pulsed low in the 2nd RUN cycle -> IDLE, no done.
//     A fresh start then completes normally.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial magnitude compare controller.
package cmp_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} cmp_state_t;

    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

    // Pack the slice flags into the one-hot {gt,eq,lt} encoding.
    function automatic logic [2:0] slice_res(input logic f1, input logic f3);
        return f1 ? RES_GT : (f3 ? RES_LT : RES_EQ);
    endfunction

endpackage

// File: rtl/Two_Bit_Cmp.sv
// Combinational 2-bit unsigned magnitude comparator: {a,b} vs {c,d}.
module Two_Bit_Cmp (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic f1,
    output logic f2,
    output logic f3
);

    assign f1 = {a, b} >  {c, d};
    assign f2 = {a, b} == {c, d};
    assign f3 = {a, b} <  {c, d};

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Serial WIDTH-bit unsigned compare built from one shared 2-bit slice, MSB pair first.
// Define CMP_EARLY_EXIT_EN to finish on the first unequal pair instead of always running P cycles.
module serial_cmp_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int P  = WIDTH / 2;
    localparam int IW = (P > 1) ? $clog2(P) : 1;
    localparam logic [IW-1:0] IDX_MAX = IW'(P - 1);

    // Handshake: start is accepted only in IDLE (busy=0); done pulses for one cycle with the
    // one-hot result, which then holds until the next accepted start. No queueing of requests.
    cmp_state_t       state, state_n;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       sticky_q, res_q;
    logic [IW:0]      bit_pos;
    logic [1:0]       pair_a, pair_b;
    logic             f1, f2, f3;
    logic             accept, exit_run;
    logic [2:0]       cur_res, final_res;

    assign accept  = (state == ST_IDLE) && start;
    assign bit_pos = {idx, 1'b0};
    assign pair_a  = a_q[bit_pos +: 2];
    assign pair_b  = b_q[bit_pos +: 2];

    Two_Bit_Cmp u_slice (
        .a  (pair_a[1]),
        .b  (pair_a[0]),
        .c  (pair_b[1]),
        .d  (pair_b[0]),
        .f1 (f1),
        .f2 (f2),
        .f3 (f3)
    );

    assign cur_res   = slice_res(f1, f3);
    // A decision made at a more significant pair always wins over the current pair.
    assign final_res = (sticky_q != RES_EQ) ? sticky_q : cur_res;

`ifdef CMP_EARLY_EXIT_EN
    assign exit_run = (idx == '0) || !f2;
`else
    assign exit_run = (idx == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (start)    state_n = ST_RUN;
            ST_RUN:  if (exit_run) state_n = ST_DONE;
            ST_DONE:               state_n = ST_IDLE;
            default:               state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            idx      <= '0;
            sticky_q <= '0;
            res_q    <= '0;
        end else if (accept) begin
            a_q      <= op_a;
            b_q      <= op_b;
            idx      <= IDX_MAX;
            sticky_q <= RES_EQ;
            res_q    <= '0;
        end else if (state == ST_RUN) begin
            if (exit_run) begin
                res_q <= final_res;
            end else begin
                idx <= idx - IW'(1);
                if (!f2 && sticky_q == RES_EQ) sticky_q <= cur_res;
            end
        end
    end

    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);
    assign {gt, eq, lt} = res_q;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Directed self-checking bench for serial_cmp_ctrl (WIDTH=8), valid for either CMP_EARLY_EXIT_EN build.
module tb_serial_cmp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;
    logic       busy, done, gt, eq, lt;

    int checks   = 0;
    int failures = 0;

    serial_cmp_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .gt    (gt),
        .eq    (eq),
        .lt    (lt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full compare: drive start for a cycle, count RUN cycles, then check the result and return to IDLE.
    task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] exp_res, input int run_full, input int run_early);
        int n;
        int exp_run;
`ifdef CMP_EARLY_EXIT_EN
        exp_run = run_early;
`else
        exp_run = run_full;
`endif
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_a  = $urandom_range(0, 255);
        op_b  = $urandom_range(0, 255);
        check({tag, "_res_cleared_in_run"}, {gt, eq, lt}, 3'b000);
        n = 0;
        while (!done && n < 20) begin
            if (busy) n++;
            @(negedge clk);
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy_in_done"}, busy, 1'b1);
        check({tag, "_run_cycles"}, n, exp_run);
        check({tag, "_result"}, {gt, eq, lt}, exp_res);
        @(negedge clk);
        check({tag, "_idle_after"}, {busy, done}, 2'b00);
        check({tag, "_result_held"}, {gt, eq, lt}, exp_res);
    endtask

    initial begin
        int n;

        // Reset behaviour
        repeat (2) @(negedge clk);
        check("reset_outputs", {busy, done, gt, eq, lt}, 5'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", {busy, done, gt, eq, lt}, 5'b0);

        // Directed compares: {gt,eq,lt}, RUN cycles full / early-exit
        run_cmp("eq_5a",    8'h5A, 8'h5A, 3'b010, 4, 4);
        run_cmp("gt_c0_40", 8'hC0, 8'h40, 3'b100, 4, 1);
        run_cmp("gt_03_02", 8'h03, 8'h02, 3'b100, 4, 4);
        run_cmp("lt_00_ff", 8'h00, 8'hFF, 3'b001, 4, 1);
        run_cmp("lt_12_13", 8'h12, 8'h13, 3'b001, 4, 4);
        run_cmp("gt_80_7f", 8'h80, 8'h7F, 3'b100, 4, 1);
        run_cmp("lt_1f_2f", 8'h1F, 8'h2F, 3'b001, 4, 2);
        run_cmp("sticky_4f_70", 8'h4F, 8'h70, 3'b001, 4, 2);
        run_cmp("eq_ff",    8'hFF, 8'hFF, 3'b010, 4, 4);

        // start held high through RUN/DONE with operands changing every cycle
        @(negedge clk);
        op_a  = 8'h90;
        op_b  = 8'h10;
        start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            op_a = 8'h00;
            op_b = 8'hFF;
            n++;
        end while (!done && n < 20);
        check("held_done", done, 1'b1);
        check("held_first_result", {gt, eq, lt}, 3'b100);
        @(negedge clk);
        check("held_start_ignored_on_done", {busy, done}, 2'b00);
        @(negedge clk);
        check("held_restart_from_idle", busy, 1'b1);
        check("held_restart_cleared", {gt, eq, lt}, 3'b000);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("held_second_result", {done, gt, eq, lt}, 4'b1001);
        @(negedge clk);

        // Reset asserted in the 2nd RUN cycle
        @(negedge clk);
        op_a  = 8'h5A;
        op_b  = 8'h5A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("midrst_in_run", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs_zero", {busy, done, gt, eq, lt}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) n++;
        end
        check("midrst_no_done", n, 0);
        run_cmp("after_rst", 8'hA5, 8'hA4, 3'b100, 4, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
